elut_cfg_writer: RTL and testbench



---
 rtl/elut_cfg_pkg.sv | 18 +
 rtl/elut_cfg_piso.sv | 48 ++++
 rtl/elut_cfg_writer.sv | 152 +++++++++++++++
 tb/tb_elut_cfg_writer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/elut_cfg_pkg.sv
// Shared definitions for the LUTRAM configuration writer: FSM encoding and
// the mask-geometry helper used to validate parameters at elaboration.
package elut_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } cfg_state_e;

    // Number of CFG_W-bit words that make up one 2^K-bit LUT mask.
    function automatic int unsigned words_per_lut(input int unsigned k,
                                                  input int unsigned cfg_w);
        return (32'd1 << k) / cfg_w;
    endfunction

endpackage

// File: rtl/elut_cfg_piso.sv
// Parallel-in/serial-out mask register: MSB leaves first, a down-counter of
// remaining bits flags the last bit of the current word.
module elut_cfg_piso #(
    parameter int unsigned CFG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [CFG_W-1:0] data_i,
    output logic             bit_o,
    output logic             last_o
);

    localparam int unsigned CNT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;

    logic [CFG_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    always_comb begin
        sr_d  = sr_q;
        rem_d = rem_q;
        if (clr_i) begin
            rem_d = '0;
        end else if (load_i) begin
            sr_d  = data_i;
            rem_d = CNT_W'(CFG_W - 1);
        end else if (shift_i) begin
            sr_d  = {sr_q[CFG_W-2:0], 1'b0};
            rem_d = rem_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q  <= '0;
            rem_q <= '0;
        end else begin
            sr_q  <= sr_d;
            rem_q <= rem_d;
        end
    end

    assign bit_o  = sr_q[CFG_W-1];
    assign last_o = (rem_q == '0);

endmodule

// File: rtl/elut_cfg_writer.sv
// Serialises a byte stream of LUT masks onto the shared LUTRAM write port,
// one mask bit per clock, programming NUM_LUTS LUTs in sequence.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_LOAD  | cfg_ready high, waiting for the next mask word
//   ST_SHIFT | one write per cycle; a/d/we show the current mask bit
//   ST_DONE  | one cycle, done pulse
module elut_cfg_writer
    import elut_cfg_pkg::*;
#(
    parameter int unsigned K        = 6,
    parameter int unsigned NUM_LUTS = 4,
    parameter int unsigned CFG_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CFG_W-1:0]    cfg_data_i,
    output logic [K-1:0]        a_o,
    output logic                d_o,
    output logic [NUM_LUTS-1:0] we_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned WORDS = words_per_lut(K, CFG_W);
    localparam int unsigned LUT_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
    localparam logic [LUT_W-1:0] LUT_LAST = LUT_W'(NUM_LUTS - 1);

    if (WORDS * CFG_W != (32'd1 << K)) begin : g_bad_geometry
        $error("elut_cfg_writer: 2^K must be a non-zero multiple of CFG_W");
    end

    cfg_state_e          state_q;
    logic [K-1:0]        addr_q;
    logic [LUT_W-1:0]    lut_q;
    logic [K-1:0]        a_q;
    logic [NUM_LUTS-1:0] we_q;
    logic                busy_q;
    logic                done_q;

    logic in_shift;
    logic bit_last;
    logic bit_cur;
    logic final_bit;
    logic hs;
    logic shift_en;
    logic issue;
    logic cancel;

    // addr_q/lut_q point at the next write; a_q/we_q describe the write in flight.
    assign in_shift  = (state_q == ST_SHIFT);
    assign final_bit = in_shift & bit_last & (a_q == '1) & we_q[NUM_LUTS-1];
    assign cfg_ready_o = ~abort_i &
                         ((state_q == ST_LOAD) | (in_shift & bit_last & ~final_bit));
    assign hs       = cfg_valid_i & cfg_ready_o;
    assign shift_en = in_shift & ~abort_i & ~bit_last;
    assign issue    = hs | shift_en;
    assign cancel   = abort_i & (state_q != ST_IDLE);

    elut_cfg_piso #(
        .CFG_W (CFG_W)
    ) u_piso (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (cancel),
        .load_i  (hs),
        .shift_i (shift_en),
        .data_i  (cfg_data_i),
        .bit_o   (bit_cur),
        .last_o  (bit_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            lut_q   <= '0;
            a_q     <= '0;
            we_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (issue) begin
                a_q    <= addr_q;
                we_q   <= NUM_LUTS'(1) << lut_q;
                addr_q <= addr_q + K'(1);
                if (addr_q == '1) begin
                    lut_q <= (lut_q == LUT_LAST) ? '0 : lut_q + LUT_W'(1);
                end
            end else begin
                we_q <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                        addr_q  <= '0;
                        lut_q   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (hs) begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (final_bit) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (bit_last && !cfg_valid_i) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (cancel) begin
                addr_q <= '0;
                lut_q  <= '0;
            end
        end
    end

    assign a_o    = a_q;
    assign d_o    = bit_cur;
    assign we_o   = we_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_elut_cfg_writer.sv
// Directed bench for elut_cfg_writer with two LUTs of 64 bits and byte input.
module tb_elut_cfg_writer;

    localparam int K      = 6;
    localparam int NL     = 2;
    localparam int CW     = 8;
    localparam int LUT_SZ = 64;
    localparam int TOTAL  = NL * LUT_SZ;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_data;
    logic [K-1:0]  a;
    logic          d;
    logic [NL-1:0] we;
    logic          busy;
    logic          done;

    logic [7:0] stream [16];
    logic [7:0] pat2   [16] = '{8'h00, 8'hFF, 8'h81, 8'h7E, 8'h12, 8'h34, 8'h56, 8'h78,
                                8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'hC3, 8'h3C, 8'h5A};

    int n_chk = 0;
    int n_bad = 0;
    int wr_tot = 0, done_tot = 0, rdy_tot = 0, gap_tot = 0, cyc_tot = 0;
    int run_base = 0, done_base = 0, rdy_base = 0, gap_base = 0;
    int load_cyc = 0, done_cyc = 0;
    logic [K-1:0]  prev_a  = '0;
    logic [NL-1:0] prev_we = '0;

    elut_cfg_writer #(.K(K), .NUM_LUTS(NL), .CFG_W(CW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_data_i  (cfg_data),
        .a_o         (a),
        .d_o         (d),
        .we_o        (we),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge and check any write in flight.
    task automatic tick();
        int n;
        logic [7:0] bt;
        @(negedge clk);
        cyc_tot++;
        if (we != '0) begin
            n  = wr_tot - run_base;
            bt = stream[(n / 8) % 16];
            chk("wr_we", 32'(we), 32'(1) << (n / LUT_SZ));
            chk("wr_a", 32'(a), 32'(n % LUT_SZ));
            chk("wr_d", 32'(d), 32'(bt[7 - (n % 8)]));
            wr_tot++;
        end else if (busy && wr_tot > run_base) begin
            gap_tot++;
        end
        if (done) begin
            chk("done_prev_we", 32'(prev_we), 32'(2));
            chk("done_prev_a", 32'(prev_a), 32'(63));
            done_tot++;
            done_cyc = cyc_tot;
        end
        if (cfg_ready) rdy_tot++;
        prev_a  = a;
        prev_we = we;
    endtask

    task automatic do_start(input logic with_abort);
        run_base  = wr_tot;
        done_base = done_tot;
        rdy_base  = rdy_tot;
        gap_base  = gap_tot;
        start = 1'b1;
        abort = with_abort;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        tick();
        load_cyc = cyc_tot;
        chk("start_ready", 32'(cfg_ready), 1);
        chk("start_busy", 32'(busy), 1);
    endtask

    task automatic feed(input int nbytes, input int stall_after, input int stall_len,
                        input int abort_at, input int poke_idx, input int exp_acc);
        int idx   = 0;
        int left  = stall_len;
        int guard = 0;
        bit hs;
        bit stop  = 1'b0;
        while (idx < nbytes && !stop && guard < 2000) begin
            guard++;
            if (we == '0 && left > 0 && idx == stall_after) left--;
            cfg_valid = !(idx == stall_after && left > 0);
            cfg_data  = stream[idx];
            start     = (idx == poke_idx);
            abort     = (abort_at >= 0 && we != '0 && int'(a) == abort_at);
            #1;
            hs = cfg_valid && cfg_ready;
            tick();
            if (hs) idx++;
            if (abort) begin
                chk("abort_we", 32'(we), 0);
                chk("abort_busy", 32'(busy), 0);
                abort = 1'b0;
                stop  = 1'b1;
            end
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        chk("bytes_acc", idx, exp_acc);
    endtask

    task automatic wait_done(input int exp_lat, input int exp_rdy, input int exp_gap);
        int guard = 0;
        while (done_tot == done_base && guard < 400) begin
            tick();
            guard++;
        end
        tick();
        tick();
        chk("done_cnt", done_tot - done_base, 1);
        chk("wr_cnt", wr_tot - run_base, TOTAL);
        chk("done_lat", done_cyc - load_cyc, exp_lat);
        chk("rdy_cnt", rdy_tot - rdy_base, exp_rdy);
        chk("gap_cnt", gap_tot - gap_base, exp_gap);
        chk("busy_end", 32'(busy), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        for (int i = 0; i < 16; i++) stream[i] = 8'hA5;

        #1;
        chk("rst_ready", 32'(cfg_ready), 0);
        chk("rst_a", 32'(a), 0);
        chk("rst_d", 32'(d), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_ready", 32'(cfg_ready), 0);
            chk("idle_we", 32'(we), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        // Back-to-back 0xA5 stream; start poked mid-run must be ignored.
        do_start(1'b0);
        feed(16, -1, 0, -1, 8, 16);
        wait_done(129, 16, 0);

        // Stall after byte 3: five dead cycles, resume at address 24.
        stream = pat2;
        do_start(1'b0);
        feed(16, 3, 5, -1, -1, 16);
        wait_done(134, 21, 5);

        // Abort while address 37 is being written.
        do_start(1'b0);
        feed(16, -1, 0, 37, -1, 5);
        repeat (3) tick();
        chk("abort_wr", wr_tot - run_base, 38);
        chk("abort_idle_ready", 32'(cfg_ready), 0);
        chk("abort_no_done", done_tot - done_base, 0);

        // Abort in LOAD refuses the offered byte.
        do_start(1'b0);
        cfg_valid = 1'b1;
        cfg_data  = 8'hFF;
        abort     = 1'b1;
        #1;
        chk("abort_load_ready", 32'(cfg_ready), 0);
        tick();
        chk("abort_load_we", 32'(we), 0);
        chk("abort_load_busy", 32'(busy), 0);
        abort     = 1'b0;
        cfg_valid = 1'b0;
        tick();
        chk("abort_load_idle", 32'(cfg_ready), 0);
        chk("abort_load_wr", wr_tot - run_base, 0);

        // start and abort together in IDLE: start wins, full run from a=0.
        do_start(1'b1);
        feed(16, -1, 0, -1, -1, 16);
        wait_done(129, 16, 0);

        // Asynchronous reset in the middle of SHIFT.
        do_start(1'b0);
        feed(2, -1, 0, -1, -1, 2);
        repeat (3) tick();
        chk("pre_rst_we", 32'(we), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(we), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(cfg_ready), 0);
        chk("arst_a", 32'(a), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_idle_we", 32'(we), 0);
            chk("arst_idle_ready", 32'(cfg_ready), 0);
        end
        chk("arst_no_done", done_tot - done_base, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
